// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free ratio reloads at period boundaries.
// Define CLK_DIV_ODD50_EN to add a falling-edge stage for exact 50% duty on odd ratios.
module clk_div_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_act_q, n_act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_rise_q, clk_rise_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] div_clamped;
  logic             wrap;
  logic             apply;

  assign half        = n_act_q >> 1;
  assign div_clamped = (div_val < WIDTH'(2)) ? WIDTH'(2) : div_val;
  assign wrap        = en && (cnt_q == n_act_q - WIDTH'(1));
  // New ratios only take effect between periods or while stopped.
  assign apply       = !en || wrap;

  always_comb begin
    cnt_d      = (!en || wrap) ? '0 : cnt_q + WIDTH'(1);
    clk_rise_d = en && (cnt_q < half);
    tick_d     = en && (cnt_q == '0);
    n_act_d    = n_act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (apply) begin
      if (div_load) begin
        n_act_d = div_clamped;
      end else if (pend_vld_q) begin
        n_act_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (div_load) begin
      pend_d     = div_clamped;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      n_act_q    <= WIDTH'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_rise_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      n_act_q    <= n_act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_rise_q <= clk_rise_d;
      tick_q     <= tick_d;
    end
  end

`ifdef CLK_DIV_ODD50_EN
  logic clk_fall_q;

  // Half-cycle delayed copy stretches the high phase by 0.5 clk for odd ratios.
  always_ff @(negedge clk) begin
    if (rst) begin
      clk_fall_q <= 1'b0;
    end else if (!n_act_q[0]) begin
      clk_fall_q <= 1'b0;
    end else begin
      clk_fall_q <= clk_rise_q;
    end
  end

  assign clk_out = clk_rise_q | clk_fall_q;
`else
  assign clk_out = clk_rise_q;
`endif

  assign tick    = tick_q;
  assign div_cur = n_act_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios then random traffic,
// compared each cycle against a period/phase reference model.
module tb_clk_div_prog;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned DEFAULT_DIV = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] div_val = '0;
  logic             div_load = 1'b0;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] div_cur;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ratio in force, pending ratio, phase of the last output cycle.
  int m_n      = DEFAULT_DIV;
  int m_pend   = 0;
  bit m_pend_vld = 1'b0;
  int m_ph     = -1;  // -1: next enabled edge starts a new period
  bit m_q      = 1'b0;

  clk_div_prog #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_val (div_val),
    .div_load(div_load),
    .clk_out (clk_out),
    .tick    (tick),
    .div_cur (div_cur)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp_div(input logic [WIDTH-1:0] v);
    return (v < 2) ? 2 : int'(v);
  endfunction

  // Drive one cycle of inputs, advance one edge, update model and compare.
  task automatic step(input bit r, input bit e, input bit l, input logic [WIDTH-1:0] v);
    bit exp_tick;
    bit exp_out;
    bit prev_q;
    int prev_n;
    int ph;
    rst      = r;
    en       = e;
    div_load = l;
    div_val  = v;
    prev_q   = m_q;
    prev_n   = m_n;
    @(posedge clk);
    exp_tick = 1'b0;
    if (r) begin
      m_n        = DEFAULT_DIV;
      m_pend_vld = 1'b0;
      m_ph       = -1;
      m_q        = 1'b0;
    end else if (!e) begin
      if (l) m_n = clamp_div(v);
      else if (m_pend_vld) m_n = m_pend;
      m_pend_vld = 1'b0;
      m_ph       = -1;
      m_q        = 1'b0;
    end else begin
      ph       = m_ph + 1;
      m_q      = (ph < m_n / 2);
      exp_tick = (ph == 0);
      if (ph == m_n - 1) begin
        m_ph = -1;
        if (l) m_n = clamp_div(v);
        else if (m_pend_vld) m_n = m_pend;
        m_pend_vld = 1'b0;
      end else begin
        m_ph = ph;
        if (l) begin
          m_pend     = clamp_div(v);
          m_pend_vld = 1'b1;
        end
      end
    end
    exp_out = m_q;
`ifdef CLK_DIV_ODD50_EN
    exp_out = m_q | (!r && (prev_n % 2 == 1) && prev_q);
`endif
    #1;
    check_eq("clk_out", 32'(clk_out), 32'(exp_out));
    check_eq("tick", 32'(tick), 32'(exp_tick));
    check_eq("div_cur", 32'(div_cur), 32'(m_n));
  endtask

  // Run enabled cycles until the counter will sit at the given value before the next edge.
  task automatic run_to_cnt(input int c);
    for (int i = 0; i < 300 && (m_ph + 1) != c; i++) step(0, 1, 0, '0);
    check_eq("reach_cnt", 32'(m_ph + 1), 32'(c));
  endtask

  initial begin
    logic [WIDTH-1:0] rv;
    // Reset state
    step(1, 0, 0, '0);
    step(1, 1, 1, 8'd5);
    check_eq("rst_div_cur", 32'(div_cur), 32'(DEFAULT_DIV));
    check_eq("rst_clk_out", 32'(clk_out), 32'd0);
    // Default ratio, two full periods
    for (int i = 0; i < 16; i++) step(0, 1, 0, '0);
    // Load 3 mid-period, current period must complete at 8
    run_to_cnt(2);
    step(0, 1, 1, 8'd3);
    for (int i = 0; i < 12; i++) step(0, 1, 0, '0);
    // Clamp 0 and 1 to 2
    step(0, 1, 1, 8'd0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, '0);
    step(0, 1, 1, 8'd1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, '0);
    // Back to 8, drop enable at cnt 5
    step(0, 1, 1, 8'd8);
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0);
    run_to_cnt(5);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0);
    // Odd ratio duty
    step(0, 0, 1, 8'd5);
    for (int i = 0; i < 12; i++) step(0, 1, 0, '0);
    // Reset with a pending load of 6 at cnt 3
    step(0, 1, 1, 8'd8);
    for (int i = 0; i < 6; i++) step(0, 1, 0, '0);
    run_to_cnt(3);
    step(0, 1, 1, 8'd6);
    step(1, 1, 0, '0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, '0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom % 4 == 0) ? WIDTH'($urandom % 256) : WIDTH'($urandom % 10);
      step(($urandom % 250) == 0, ($urandom % 20) != 0, ($urandom % 10) == 0, rv);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
